// File: rtl/axi_sp_mem_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// AXI_BUS : AXI4 bus bundle carrying the AW/W/B/AR/R channels.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4
);
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface
`default_nettype wire

// File: rtl/axi_sp_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_sp_mem_ctrl : AXI4 slave sequencing a 1-cycle-latency single-port SRAM.
// Optional: AXI_SP_MEM_RANGE_CHECK_EN returns DECERR for out-of-range bursts.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module axi_sp_mem_ctrl #(
    parameter int unsigned  AXI_ADDR_WIDTH = 32,
    parameter int unsigned  AXI_DATA_WIDTH = 64,
    parameter int unsigned  AXI_ID_WIDTH   = 4,
    parameter int unsigned  AXI_USER_WIDTH = 4,
    parameter int unsigned  MEM_DEPTH      = 1024,
    localparam int unsigned MEM_AW         = $clog2(MEM_DEPTH),
    localparam int unsigned STRB           = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    AXI_BUS.Slave                     slave,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_AW-1:0]         mem_addr,
    output logic [STRB-1:0]           mem_be,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);
    localparam int unsigned       OFF       = $clog2(STRB);
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(MEM_DEPTH - 1);
    localparam logic [1:0]        BURST_FIXED = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RREQ  = 3'd3,
        RDATA = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic                      last_wr_q, last_wr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [MEM_AW-1:0]         addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [1:0]                burst_q, burst_d;
    logic [8:0]                beat_q, beat_d;
    logic                      err_q, err_d;
    logic                      oor_q, oor_d;
    logic                      rfirst_q, rfirst_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                      w_grant_w, w_grant_r, w_sel_oor, w_is_last;
    logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
    logic [MEM_AW-1:0]         w_addr_inc, w_addr_adv;
    logic                      w_unused;

    // Grants are withheld during reset so no handshake is lost to the reset edge.
    assign w_grant_w  = rst_n && (state_q == IDLE) && slave.aw_valid && (!slave.ar_valid || !last_wr_q);
    assign w_grant_r  = rst_n && (state_q == IDLE) && slave.ar_valid && (!slave.aw_valid || last_wr_q);
    assign w_sel_addr = w_grant_w ? slave.aw_addr : slave.ar_addr;
    assign w_is_last  = (beat_q == {1'b0, len_q});
    assign w_addr_inc = (addr_q == LAST_WORD) ? '0 : addr_q + MEM_AW'(1);
    assign w_addr_adv = (burst_q == BURST_FIXED) ? addr_q : w_addr_inc;

`ifdef AXI_SP_MEM_RANGE_CHECK_EN
    localparam int unsigned       WIDX_W  = AXI_ADDR_WIDTH - OFF;
    localparam logic [WIDX_W-1:0] DEPTH_W = WIDX_W'(MEM_DEPTH);
    assign w_sel_oor = (w_sel_addr[AXI_ADDR_WIDTH-1:OFF] >= DEPTH_W);
`else
    assign w_sel_oor = 1'b0;
`endif

    assign w_unused = ^{slave.aw_size, slave.ar_size, slave.aw_user, slave.ar_user,
                        slave.w_user, w_sel_addr};

    assign mem_addr     = addr_q;
    assign slave.b_id   = id_q;
    assign slave.r_id   = id_q;
    assign slave.b_user = {AXI_USER_WIDTH{1'b0}};
    assign slave.r_user = {AXI_USER_WIDTH{1'b0}};
    assign slave.b_resp = oor_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
    assign slave.r_resp = oor_q ? 2'b11 : 2'b00;
    // Memory data is only valid in the first RDATA cycle; afterwards the captured copy is shown.
    assign slave.r_data = oor_q ? '0 : (rfirst_q ? mem_rdata : rdata_q);

    always_comb begin
        state_d        = state_q;
        last_wr_d      = last_wr_q;
        id_d           = id_q;
        addr_d         = addr_q;
        len_d          = len_q;
        burst_d        = burst_q;
        beat_d         = beat_q;
        err_d          = err_q;
        oor_d          = oor_q;
        rfirst_d       = 1'b0;
        rdata_d        = rdata_q;
        slave.aw_ready = w_grant_w;
        slave.ar_ready = w_grant_r;
        slave.w_ready  = 1'b0;
        slave.b_valid  = 1'b0;
        slave.r_valid  = 1'b0;
        slave.r_last   = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_be         = '0;
        mem_wdata      = '0;
        case (state_q)
            IDLE: begin
                if (w_grant_w || w_grant_r) begin
                    id_d      = w_grant_w ? slave.aw_id : slave.ar_id;
                    addr_d    = w_sel_addr[MEM_AW+OFF-1:OFF];
                    len_d     = w_grant_w ? slave.aw_len : slave.ar_len;
                    burst_d   = w_grant_w ? slave.aw_burst : slave.ar_burst;
                    beat_d    = '0;
                    err_d     = 1'b0;
                    oor_d     = w_sel_oor;
                    last_wr_d = w_grant_w;
                    state_d   = w_grant_w ? WDATA : RREQ;
                end
            end
            WDATA: begin
                slave.w_ready = 1'b1;
                mem_req       = slave.w_valid && !oor_q;
                mem_we        = 1'b1;
                mem_be        = slave.w_strb;
                mem_wdata     = slave.w_data;
                if (slave.w_valid) begin
                    addr_d = w_addr_adv;
                    beat_d = (beat_q == '1) ? beat_q : beat_q + 9'd1;
                    if ((beat_q > {1'b0, len_q}) || (slave.w_last && !w_is_last)) begin
                        err_d = 1'b1;
                    end
                    if (slave.w_last) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                slave.b_valid = 1'b1;
                if (slave.b_ready) begin
                    state_d = IDLE;
                end
            end
            RREQ: begin
                mem_req  = !oor_q;
                rfirst_d = 1'b1;
                state_d  = RDATA;
            end
            RDATA: begin
                slave.r_valid = 1'b1;
                slave.r_last  = w_is_last;
                if (rfirst_q) begin
                    rdata_d = mem_rdata;
                end
                if (slave.r_ready) begin
                    if (w_is_last) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = w_addr_adv;
                        beat_d  = beat_q + 9'd1;
                        state_d = RREQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
            oor_q     <= 1'b0;
            rfirst_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
            oor_q     <= oor_d;
            rfirst_q  <= rfirst_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axi_sp_mem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_sp_mem_ctrl : directed bench for axi_sp_mem_ctrl with an SRAM model.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_axi_sp_mem_ctrl;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4)) bus ();

    axi_sp_mem_ctrl #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(4), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slave(bus),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [63:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    logic [9:0]  wr_a[$];
    logic [7:0]  wr_be[$];
    logic [63:0] wr_d[$];
    logic [9:0]  rd_a[$];
    int          grants[$];
    always @(negedge clk) begin
        if (mem_req && mem_we) begin
            wr_a.push_back(mem_addr); wr_be.push_back(mem_be); wr_d.push_back(mem_wdata);
        end
        if (mem_req && !mem_we) rd_a.push_back(mem_addr);
        if (bus.aw_valid && bus.aw_ready) grants.push_back(1);
        if (bus.ar_valid && bus.ar_ready) grants.push_back(0);
    end

    int nvec = 0;
    int nfail = 0;
    logic [7:0] strb_pat [0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        nvec++; nfail++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input int nbeats, input logic [63:0] d0,
                            output logic [1:0] resp, output logic [3:0] bid);
        int t;
        resp = 2'bxx; bid = 4'hx;
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_burst = burst;
        bus.aw_size = 3'd3; bus.aw_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.aw_ready && t < 200);
        if (!bus.aw_ready) begin tmo("aw"); bus.aw_valid = 1'b0; return; end
        @(posedge clk); #1 bus.aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            bus.w_data = d0 + 64'(i); bus.w_strb = strb_pat[i];
            bus.w_last = (i == nbeats - 1); bus.w_valid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.w_ready && t < 200);
            if (!bus.w_ready) begin tmo("w"); bus.w_valid = 1'b0; return; end
            @(posedge clk); #1;
        end
        bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.b_valid && t < 200);
        if (!bus.b_valid) begin tmo("b"); bus.b_ready = 1'b0; return; end
        resp = bus.b_resp; bid = bus.b_id;
        @(posedge clk); #1 bus.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, output logic [63:0] dfirst,
                           output logic [63:0] dlast, output logic [1:0] rsp, output int nb,
                           output int nlast, output logic [3:0] rid);
        int t;
        bit done;
        dfirst = 'x; dlast = 'x; rsp = 2'b00; nb = 0; nlast = 0; rid = 4'hx; done = 1'b0;
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_burst = burst;
        bus.ar_size = 3'd3; bus.ar_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.ar_ready && t < 200);
        if (!bus.ar_ready) begin tmo("ar"); bus.ar_valid = 1'b0; return; end
        @(posedge clk); #1 bus.ar_valid = 1'b0; bus.r_ready = 1'b1;
        while (!done && nb < 64) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.r_valid && t < 200);
            if (!bus.r_valid) begin tmo("r"); bus.r_ready = 1'b0; return; end
            if (nb == 0) dfirst = bus.r_data;
            dlast = bus.r_data; rsp = rsp | bus.r_resp; rid = bus.r_id;
            if (bus.r_last) nlast++;
            done = bus.r_last; nb++;
            @(posedge clk); #1;
        end
        bus.r_ready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [63:0] d0;
        logic [7:0]  strb;
        logic [1:0]  resp;
        int          n;      // expected memory accesses
        logic [9:0]  a0, a1; // first/last memory address
        logic [63:0] e0, e1; // first/last data (written or returned)
    } vec_t;
    vec_t vt [0:10];

    logic [1:0]  resp;
    logic [3:0]  bid, rid;
    logic [63:0] d_a, d_b, d_c, d_d;
    int          nb, nl, nb2, nl2, w0, r0;
    logic [1:0]  rsp2;
    logic [3:0]  rid2;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        vt[0] = '{1'b1, 4'd3,  32'h10,   8'd3, 2'b01, 64'hA0, 8'hFF, 2'b00, 4, 10'd2,    10'd5, 64'hA0, 64'hA3};
        vt[1] = '{1'b0, 4'd5,  32'h10,   8'd3, 2'b01, 64'h0,  8'h00, 2'b00, 4, 10'd2,    10'd5, 64'hA0, 64'hA3};
        vt[2] = '{1'b1, 4'd1,  32'h40,   8'd2, 2'b00, 64'h11, 8'hFF, 2'b00, 3, 10'd8,    10'd8, 64'h11, 64'h13};
        vt[3] = '{1'b0, 4'd2,  32'h40,   8'd0, 2'b01, 64'h0,  8'h00, 2'b00, 1, 10'd8,    10'd8, 64'h13, 64'h13};
        vt[4] = '{1'b1, 4'd7,  32'h1FF8, 8'd1, 2'b01, 64'h50, 8'hFF, 2'b00, 2, 10'd1023, 10'd0, 64'h50, 64'h51};
        vt[5] = '{1'b0, 4'd6,  32'h1FF8, 8'd1, 2'b01, 64'h0,  8'h00, 2'b00, 2, 10'd1023, 10'd0, 64'h50, 64'h51};
        vt[6] = '{1'b1, 4'd9,  32'h28,   8'd1, 2'b00, 64'hDEADBEEF_00000070, 8'hF0, 2'b00, 2, 10'd5, 10'd5,
                  64'hDEADBEEF_00000070, 64'hDEADBEEF_00000071};
        vt[7] = '{1'b0, 4'd10, 32'h28,   8'd0, 2'b01, 64'h0,  8'h00, 2'b00, 1, 10'd5,    10'd5,
                  64'hDEADBEEF_000000A3, 64'hDEADBEEF_000000A3};
`ifdef AXI_SP_MEM_RANGE_CHECK_EN
        vt[8]  = '{1'b0, 4'd11, 32'h2000, 8'd1, 2'b01, 64'h0,  8'h00, 2'b11, 0, 10'd0, 10'd0, 64'h0, 64'h0};
        vt[9]  = '{1'b1, 4'd12, 32'h2008, 8'd0, 2'b01, 64'h99, 8'hFF, 2'b11, 0, 10'd0, 10'd0, 64'h0, 64'h0};
        vt[10] = '{1'b0, 4'd13, 32'h08,   8'd0, 2'b01, 64'h0,  8'h00, 2'b00, 1, 10'd1, 10'd1, 64'h0, 64'h0};
`else
        vt[8]  = '{1'b0, 4'd11, 32'h2000, 8'd1, 2'b01, 64'h0,  8'h00, 2'b00, 2, 10'd0, 10'd1, 64'h51, 64'h0};
        vt[9]  = '{1'b1, 4'd12, 32'h2008, 8'd0, 2'b01, 64'h99, 8'hFF, 2'b00, 1, 10'd1, 10'd1, 64'h99, 64'h99};
        vt[10] = '{1'b0, 4'd13, 32'h08,   8'd0, 2'b01, 64'h0,  8'h00, 2'b00, 1, 10'd1, 10'd1, 64'h99, 64'h99};
`endif
        bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
        bus.aw_user = '0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0; bus.w_user = '0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0; bus.ar_user = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
        bus.aw_valid = 1'b1;

        // Reset state, with aw_valid held high to show no grant leaks through reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst aw_ready", 64'(bus.aw_ready), 64'd0);
        chk("rst ctrl", 64'({bus.w_ready, bus.b_valid, bus.r_valid, bus.r_last, mem_req, mem_we}), 64'd0);
        chk("rst r_data", bus.r_data, 64'd0);
        chk("rst ids/resp", 64'({bus.b_id, bus.r_id, bus.b_resp, bus.r_resp}), 64'd0);
        bus.aw_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Tie after reset: read first, then write; next tie goes to the write.
        for (int i = 0; i < 16; i++) strb_pat[i] = 8'hFF;
        fork
            begin
                do_read(4'd1, 32'h800, 8'd0, 2'b01, d_a, d_b, rsp2, nb2, nl2, rid2);
                do_read(4'd2, 32'h800, 8'd0, 2'b01, d_c, d_d, rsp2, nb2, nl2, rid2);
            end
            do_write(4'd3, 32'h800, 8'd0, 2'b01, 1, 64'h5A, resp, bid);
        join
        chk("tie n_grants", 64'(grants.size()), 64'd3);
        chk("tie grant0 is AR", 64'(grants.size() > 0 ? grants[0] : 9), 64'd0);
        chk("tie grant1 is AW", 64'(grants.size() > 1 ? grants[1] : 9), 64'd1);
        chk("tie grant2 is AR", 64'(grants.size() > 2 ? grants[2] : 9), 64'd0);
        chk("tie read before write", d_a, 64'h0);
        chk("tie read after write", d_c, 64'h5A);

        for (int i = 0; i < 11; i++) begin
            w0 = wr_a.size(); r0 = rd_a.size();
            if (vt[i].wr) begin
                for (int k = 0; k < 16; k++) strb_pat[k] = vt[i].strb;
                do_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, int'(vt[i].len) + 1,
                         vt[i].d0, resp, bid);
                chk($sformatf("v%0d b_resp", i), 64'(resp), 64'(vt[i].resp));
                chk($sformatf("v%0d b_id", i), 64'(bid), 64'(vt[i].id));
                chk($sformatf("v%0d n_writes", i), 64'(wr_a.size() - w0), 64'(vt[i].n));
                if (vt[i].n > 0 && wr_a.size() > w0) begin
                    chk($sformatf("v%0d first waddr", i), 64'(wr_a[w0]), 64'(vt[i].a0));
                    chk($sformatf("v%0d last waddr", i), 64'(wr_a[wr_a.size()-1]), 64'(vt[i].a1));
                    chk($sformatf("v%0d first wdata", i), wr_d[w0], vt[i].e0);
                    chk($sformatf("v%0d last wdata", i), wr_d[wr_d.size()-1], vt[i].e1);
                end
            end else begin
                do_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, d_a, d_b, resp, nb, nl, rid);
                chk($sformatf("v%0d r_resp", i), 64'(resp), 64'(vt[i].resp));
                chk($sformatf("v%0d r_id", i), 64'(rid), 64'(vt[i].id));
                chk($sformatf("v%0d beats", i), 64'(nb), 64'(int'(vt[i].len) + 1));
                chk($sformatf("v%0d r_last count", i), 64'(nl), 64'd1);
                chk($sformatf("v%0d first rdata", i), d_a, vt[i].e0);
                chk($sformatf("v%0d last rdata", i), d_b, vt[i].e1);
                chk($sformatf("v%0d n_reads", i), 64'(rd_a.size() - r0), 64'(vt[i].n));
                if (vt[i].n > 0 && rd_a.size() > r0) begin
                    chk($sformatf("v%0d first raddr", i), 64'(rd_a[r0]), 64'(vt[i].a0));
                    chk($sformatf("v%0d last raddr", i), 64'(rd_a[rd_a.size()-1]), 64'(vt[i].a1));
                end
            end
        end

        // Read back-pressure: 5 stalled cycles on beat 0.
        bus.ar_id = 4'd4; bus.ar_addr = 32'h10; bus.ar_len = 8'd1; bus.ar_burst = 2'b01;
        bus.ar_valid = 1'b1;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!bus.ar_ready && w0 < 200);
        if (!bus.ar_ready) tmo("stall ar");
        @(posedge clk); #1 bus.ar_valid = 1'b0;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!bus.r_valid && w0 < 200);
        if (!bus.r_valid) tmo("stall r");
        r0 = rd_a.size();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d r_valid", c), 64'(bus.r_valid), 64'd1);
            chk($sformatf("stall%0d r_data", c), bus.r_data, 64'hA0);
            chk($sformatf("stall%0d no new mem_req", c), 64'(rd_a.size()), 64'(r0));
        end
        bus.r_ready = 1'b1;
        @(posedge clk); #1;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!bus.r_valid && w0 < 200);
        chk("stall beat1 data", bus.r_data, 64'hA1);
        chk("stall beat1 r_last", 64'(bus.r_last), 64'd1);
        @(posedge clk); #1 bus.r_ready = 1'b0;

        // Early w_last, then a clean burst, then an extra beat.
        for (int k = 0; k < 16; k++) strb_pat[k] = 8'hFF;
        w0 = wr_a.size();
        do_write(4'd2, 32'h100, 8'd3, 2'b01, 2, 64'hE0, resp, bid);
        chk("early last b_resp", 64'(resp), 64'h2);
        chk("early last n_writes", 64'(wr_a.size() - w0), 64'd2);
        do_write(4'd2, 32'h100, 8'd0, 2'b01, 1, 64'hE5, resp, bid);
        chk("clean after err b_resp", 64'(resp), 64'h0);
        w0 = wr_a.size();
        do_write(4'd2, 32'h100, 8'd0, 2'b01, 2, 64'hE8, resp, bid);
        chk("extra beat b_resp", 64'(resp), 64'h2);
        chk("extra beat n_writes", 64'(wr_a.size() - w0), 64'd2);

        // FIXED burst with changing strobes.
        strb_pat[0] = 8'h0F; strb_pat[1] = 8'hF0; strb_pat[2] = 8'hFF;
        w0 = wr_a.size();
        do_write(4'd4, 32'h40, 8'd2, 2'b00, 3, 64'h01020304_05060708, resp, bid);
        chk("fixed b_resp", 64'(resp), 64'h0);
        chk("fixed n_writes", 64'(wr_a.size() - w0), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (wr_a.size() > w0 + k) begin
                chk($sformatf("fixed beat%0d addr", k), 64'(wr_a[w0+k]), 64'd8);
                chk($sformatf("fixed beat%0d be", k), 64'(wr_be[w0+k]), 64'(strb_pat[k]));
            end
        end
        do_read(4'd4, 32'h40, 8'd0, 2'b01, d_a, d_b, resp, nb, nl, rid);
        chk("fixed readback", d_a, 64'h01020304_0506070A);

        // Reset during RDATA of a 4-beat read.
        bus.ar_id = 4'd8; bus.ar_addr = 32'h10; bus.ar_len = 8'd3; bus.ar_burst = 2'b01;
        bus.ar_valid = 1'b1;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!bus.ar_ready && w0 < 200);
        @(posedge clk); #1 bus.ar_valid = 1'b0;
        w0 = 0;
        do begin @(negedge clk); w0++; end while (!bus.r_valid && w0 < 200);
        chk("midrst beat0 data", bus.r_data, 64'hA0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst r_valid", 64'(bus.r_valid), 64'd0);
        chk("midrst b_valid/mem_req", 64'({bus.b_valid, mem_req}), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_read(4'd9, 32'h18, 8'd0, 2'b01, d_a, d_b, resp, nb, nl, rid);
        chk("post-rst read data", d_a, 64'hA1);
        chk("post-rst read resp", 64'(resp), 64'h0);
        chk("post-rst read id", 64'(rid), 64'd9);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_sp_mem_ctrl.md
Name: axi_sp_mem_ctrl

Overview:
AXI4 slave controller that sequences a single-ported, 1-cycle-latency SRAM behind an AXI_BUS.Slave port. It arbitrates round-robin between the AW/W and AR channels, since only one burst owns the memory at a time. It converts bursts into per-beat memory accesses and generates the B and R responses. It sits between the peripheral/AXI interconnect and local data/instruction RAM banks.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width
AXI_DATA_WIDTH, 64, AXI and memory data width; STRB = AXI_DATA_WIDTH/8
AXI_ID_WIDTH, 4, AXI ID width
AXI_USER_WIDTH, 4, AXI user width; user outputs are driven to 0
MEM_DEPTH, 1024, memory depth in words; MEM_AW = $clog2(MEM_DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
slave  AXI_BUS.Slave  -  AXI4 slave port carrying all AW/W/B/AR/R signals
mem_req  out  1  memory access strobe
mem_we  out  1  1 = write, 0 = read
mem_addr  out  MEM_AW  word address
mem_be  out  STRB  byte enables, meaningful for writes only
mem_wdata  out  AXI_DATA_WIDTH  write data
mem_rdata  in  AXI_DATA_WIDTH  read data, valid the cycle after a read mem_req

Behaviour:
- Single clock, clk. Synchronous active-low reset, rst_n.
- Reset values: aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last, mem_req and mem_we are 0. All data, id, resp, user and address outputs are 0. Round-robin pointer last_wr = 1, so a read wins the first tie.
- Word address: addr[AXI_ADDR_WIDTH-1:$clog2(STRB)], truncated to MEM_AW bits. Word addresses wrap modulo MEM_DEPTH.
- Burst address step:
  - INCR: address +1 word per beat.
  - FIXED: address constant across the burst.
  - WRAP: treated as INCR.
- aw_size and ar_size are ignored; every beat is full-width.
- FSM states: IDLE, WDATA, WRESP, RREQ, RDATA.
- IDLE:
  - aw_ready and ar_ready are combinational grants.
  - Only one of aw_valid/ar_valid set: grant it.
  - Both set: grant the channel not served last.
  - On grant, latch id, word address, len, burst type; beat count = 0; update last_wr.
  - AW grant goes to WDATA; AR grant goes to RREQ.
- WDATA:
  - w_ready = 1.
  - mem_req = w_valid, mem_we = 1, mem_be = w_strb, mem_wdata = w_data, at the current address.
  - Each W handshake advances the address and beat count.
  - On the handshake with w_last = 1, go to WRESP.
  - resp_err is set if w_last arrives on a beat != len, or a beat > len arrives; such extra beats are still written.
- WRESP:
  - b_valid = 1, b_id = latched id.
  - b_resp = 2'b10 (SLVERR) if resp_err, else 2'b00.
  - Hold until b_ready, then go to IDLE.
- RREQ: mem_req = 1, mem_we = 0 for one cycle, then go to RDATA.
- RDATA:
  - r_data is registered from mem_rdata on RDATA entry and held stable while r_valid && !r_ready.
  - r_valid = 1, r_id = latched id, r_resp = 2'b00, r_last = (beat == len).
  - On handshake: if last, go to IDLE; else advance address and beat, go to RREQ.
- Throughput: read is 2 cycles/beat minimum. Write is 1 cycle/beat plus 1 response cycle minimum.
- The channel that does not own the memory sees its ready held at 0.
- rst_n low mid-burst: the burst is aborted, FSM goes to IDLE, no B/R response is issued, and outputs return to reset values on the next edge.
- AXI rule: valid outputs never depend on ready inputs in the same cycle; once asserted, b_valid/r_valid are held with stable payload until their handshake.

Optional Feature:
AXI_SP_MEM_RANGE_CHECK_EN:
- Defined: a burst whose AXI address, before truncation, has a word index >= MEM_DEPTH is an out-of-range burst.
  - Write: all W beats are accepted with mem_req = 0; response b_resp = 2'b11 (DECERR).
  - Read: no mem_req; each beat returns r_data = 0, r_resp = 2'b11, with normal r_last sequencing.
- Undefined: addresses truncate silently and wrap into memory; DECERR is never produced.

Test Plan:
- AW addr 0x10, len 3, INCR; 4 W beats, data 0xA0..0xA3, strb 0xFF -> mem writes at word 2..5; b_resp 00, b_id = aw_id. Then AR addr 0x10, len 3 -> R returns 0xA0..0xA3, r_last on 4th beat only.
- aw_valid and ar_valid asserted same cycle after reset -> AR granted first, then AW. Repeat the tie -> AW granted first (alternation).
- Read len 1 with r_ready low for 5 cycles on beat 0 -> r_data and r_valid stable; no second mem_req until the handshake.
- Write len 3 with w_last on beat 1 -> 2 writes performed, b_resp = 2'b10. Next burst returns OKAY.
- FIXED write len 2 to addr 0x40 with strb 0x0F, 0xF0, 0xFF -> three writes to word 8 with matching mem_be.
- rst_n low during RDATA of a 4-beat read -> r_valid = 0 next cycle, FSM IDLE, new AR accepted normally. With AXI_SP_MEM_RANGE_CHECK_EN: read at word MEM_DEPTH -> r_resp 11, mem_req never asserted.
